// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings for the load/store unit host port.
//   lsu_size_e  - access size encoding as presented on lsu_size_i
//   lsu_state_e - lsu_host FSM state encoding
//   lsu_misaligned() - legality check for a size/offset pair
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    RDATA = 3'd2,
    WR    = 3'd3,
    DONE  = 3'd4
  } lsu_state_e;

  // True for the illegal size code and for any half/word access that is
  // not naturally aligned.
  function automatic logic lsu_misaligned(input lsu_size_e size, input logic [1:0] off);
    logic bad;
    unique case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = off[0];
      SZ_WORD: bad = (off != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational lane handling for lsu_host.
//   size_i, unsigned_i, offset_i : registered access attributes
//   word_i   : aligned word returned by the bus
//   wdata_i  : LSB-aligned store data from the core
//   load_o   : selected byte/half/word, sign- or zero-extended
//   merge_o  : word_i with the store lane replaced (full wdata_i for words)
module lsu_align
  import lsu_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  lsu_size_e              size_i,
  input  logic                   unsigned_i,
  input  logic [1:0]             offset_i,
  input  logic [DataWidth-1:0]   word_i,
  input  logic [DataWidth-1:0]   wdata_i,
  output logic [DataWidth-1:0]   load_o,
  output logic [DataWidth-1:0]   merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[{offset_i, 3'b000} +: 8];
    half_sel = word_i[{offset_i[1], 4'b0000} +: 16];

    load_o = word_i;
    unique case (size_i)
      SZ_BYTE: load_o = {{(DataWidth-8){byte_sel[7] & ~unsigned_i}}, byte_sel};
      SZ_HALF: load_o = {{(DataWidth-16){half_sel[15] & ~unsigned_i}}, half_sel};
      default: load_o = word_i;
    endcase

    merge_o = word_i;
    unique case (size_i)
      SZ_BYTE: merge_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
      SZ_HALF: merge_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      default: merge_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_host.sv
// lsu_host: single-outstanding load/store unit driving one system-bus host port.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   lsu_req_i/we_i/size_i/unsigned_i/addr_i/wdata_i : core request, sampled in IDLE
//   lsu_busy_o          : transaction in flight, requests ignored
//   lsu_done_o          : one-cycle completion pulse
//   lsu_err_o/rdata_o   : completion status and extended load data, held until next completion
//   bus_req_o/gnt_i/addr_o/we_o/wdata_o/rdata_i : bus host port; rdata valid one cycle after grant
// Sub-word stores are read-modify-write: read the word, merge the lane, write it back.
module lsu_host
  import lsu_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    lsu_req_i,
  input  logic                    lsu_we_i,
  input  logic [1:0]              lsu_size_i,
  input  logic                    lsu_unsigned_i,
  input  logic [AddressWidth-1:0] lsu_addr_i,
  input  logic [DataWidth-1:0]    lsu_wdata_i,
  output logic                    lsu_busy_o,
  output logic                    lsu_done_o,
  output logic                    lsu_err_o,
  output logic [DataWidth-1:0]    lsu_rdata_o,
  output logic                    bus_req_o,
  input  logic                    bus_gnt_i,
  output logic [AddressWidth-1:0] bus_addr_o,
  output logic                    bus_we_o,
  output logic [DataWidth-1:0]    bus_wdata_o,
  input  logic [DataWidth-1:0]    bus_rdata_i
);

  lsu_state_e              state_q, state_d;
  logic                    we_q;
  lsu_size_e               size_q;
  logic                    uns_q;
  logic [AddressWidth-1:0] addr_q;
  logic [DataWidth-1:0]    wword_q;
  logic [DataWidth-1:0]    rdata_q;
  logic                    err_q;

  lsu_size_e               req_size;
  logic                    req_err;
  logic [DataWidth-1:0]    load_data;
  logic [DataWidth-1:0]    merge_data;

  assign req_size = lsu_size_e'(lsu_size_i);
  assign req_err  = lsu_misaligned(req_size, lsu_addr_i[1:0]);

  lsu_align #(
    .DataWidth(DataWidth)
  ) u_align (
    .size_i    (size_q),
    .unsigned_i(uns_q),
    .offset_i  (addr_q[1:0]),
    .word_i    (bus_rdata_i),
    .wdata_i   (wword_q),
    .load_o    (load_data),
    .merge_o   (merge_data)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (lsu_req_i) begin
          if (req_err)                          state_d = DONE;
          else if (lsu_we_i && req_size == SZ_WORD) state_d = WR;
          else                                  state_d = RD;
        end
      end
      RD:      if (bus_gnt_i) state_d = RDATA;
      RDATA:   state_d = we_q ? WR : DONE;
      WR:      if (bus_gnt_i) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are decoded from state alone so that an asynchronous reset
  // drops them in the same instant as the state register.
  always_comb begin
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_wdata_o = '0;
    unique case (state_q)
      RD: begin
        bus_req_o  = 1'b1;
        bus_addr_o = {addr_q[AddressWidth-1:2], 2'b00};
      end
      WR: begin
        bus_req_o   = 1'b1;
        bus_we_o    = 1'b1;
        bus_addr_o  = {addr_q[AddressWidth-1:2], 2'b00};
        bus_wdata_o = wword_q;
      end
      default: ;
    endcase
  end

  assign lsu_busy_o  = (state_q != IDLE);
  assign lsu_done_o  = (state_q == DONE);
  assign lsu_err_o   = err_q;
  assign lsu_rdata_o = rdata_q;

  // wword_q holds raw store data until RDATA, then the merged word for WR.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wword_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (lsu_req_i) begin
            we_q    <= lsu_we_i;
            size_q  <= req_size;
            uns_q   <= lsu_unsigned_i;
            addr_q  <= lsu_addr_i;
            wword_q <= lsu_wdata_i;
            if (req_err) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
            end
          end
        end
        RDATA: begin
          if (we_q) begin
            wword_q <= merge_data;
          end else begin
            rdata_q <= load_data;
            err_q   <= 1'b0;
          end
        end
        WR: begin
          if (bus_gnt_i) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_host.sv
module tb_lsu_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        bus_req, bus_gnt, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_host #(.DataWidth(32), .AddressWidth(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .lsu_req_i(req), .lsu_we_i(we), .lsu_size_i(size), .lsu_unsigned_i(uns),
    .lsu_addr_i(addr), .lsu_wdata_i(wdata),
    .lsu_busy_o(busy), .lsu_done_o(done), .lsu_err_o(err), .lsu_rdata_o(rdata),
    .bus_req_o(bus_req), .bus_gnt_i(bus_gnt), .bus_addr_o(bus_addr),
    .bus_we_o(bus_we), .bus_wdata_o(bus_wdata), .bus_rdata_i(bus_rdata)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- bus slave with memory ----------------
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  bit [31:0] mem [bit [31:0]];
  op_t ops_q[$];
  op_t exp_ops[$];
  int  stall_left = 0;
  bit  rd_pend;
  logic [31:0] rd_addr;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  initial begin
    op_t o;
    bus_gnt   = 1'b0;
    bus_rdata = 32'h5A5A_5A5A;
    rd_pend   = 1'b0;
    rd_addr   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rd_pend = 1'b0;
      end else if (bus_req && bus_gnt) begin
        o.we = bus_we; o.addr = bus_addr; o.data = bus_wdata;
        ops_q.push_back(o);
        if (bus_we) mem[bus_addr] = bus_wdata;
        else begin rd_pend = 1'b1; rd_addr = bus_addr; end
      end
      @(posedge clk);
      #1;
      if (rd_pend) begin bus_rdata = mem_rd(rd_addr); rd_pend = 1'b0; end
      else bus_rdata = 32'h5A5A_5A5A;
      if (bus_req && !rst) begin
        if (stall_left > 0) begin bus_gnt = 1'b0; stall_left--; end
        else bus_gnt = 1'b1;
      end else bus_gnt = 1'b0;
    end
  end

  // ---------------- behavioural model ----------------
  bit          m_active = 1'b0;
  int          m_start = 0, m_done = 0, done_seen = -100, last_start = 0;
  logic        m_err_p, held_err = 1'b0;
  logic [31:0] m_rdata_p, held_rdata = '0;

  task automatic start_txn(input logic t_we, input logic [1:0] t_size, input logic t_uns,
                           input logic [31:0] t_addr, input logic [31:0] t_wdata, input int stall);
    logic [31:0] w, raw, v, mask, aligned;
    int sh, lat;
    op_t o;
    aligned = t_addr & 32'hFFFF_FFFC;
    w  = mem_rd(aligned);
    sh = int'(t_addr[1:0]) * 8;
    m_err_p = (t_size == 2'b11) || (t_size == 2'b01 && t_addr[0]) ||
              (t_size == 2'b10 && t_addr[1:0] != 2'b00);
    exp_ops.delete();
    ops_q.delete();
    m_rdata_p = 32'h0;
    if (m_err_p) begin
      lat = 1; stall = 0;
    end else if (!t_we) begin
      raw = w >> sh;
      if (t_size == 2'b00) begin
        v = raw & 32'hFF;
        if (!t_uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (t_size == 2'b01) begin
        v = raw & 32'hFFFF;
        if (!t_uns && v[15]) v = v | 32'hFFFF_0000;
      end else v = w;
      m_rdata_p = v;
      o.we = 1'b0; o.addr = aligned; o.data = 32'h0; exp_ops.push_back(o);
      lat = 3;
    end else if (t_size == 2'b10) begin
      o.we = 1'b1; o.addr = aligned; o.data = t_wdata; exp_ops.push_back(o);
      lat = 2;
    end else begin
      mask = ((t_size == 2'b00) ? 32'hFF : 32'hFFFF) << sh;
      o.we = 1'b0; o.addr = aligned; o.data = 32'h0; exp_ops.push_back(o);
      o.we = 1'b1; o.data = (w & ~mask) | ((t_wdata << sh) & mask); exp_ops.push_back(o);
      lat = 4;
    end
    stall_left = stall;
    req = 1'b1; we = t_we; size = t_size; uns = t_uns; addr = t_addr; wdata = t_wdata;
    m_start    = cyc + 1;
    last_start = m_start;
    m_done     = cyc + lat + stall;
    done_seen  = -100;
    m_active   = 1'b1;
  endtask

  task automatic finish_txn(input bit hold);
    int g = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!m_active) break;
      g++;
      if (g > 64) begin
        chk("txn_timeout", 32'(g), 32'h0);
        m_active = 1'b0;
        break;
      end
      if (hold) begin
        req = 1'b1; we = 1'b1; size = 2'b10; addr = 32'h3000; wdata = 32'hBAD0_BAD0;
      end else req = 1'b0;
    end
    req = 1'b0; we = 1'b0; size = 2'b00; addr = '0; wdata = '0;
    chk("bus_op_count", 32'(ops_q.size()), 32'(exp_ops.size()));
    for (int i = 0; i < exp_ops.size() && i < ops_q.size(); i++) begin
      chk("bus_op_we",   32'(ops_q[i].we), 32'(exp_ops[i].we));
      chk("bus_op_addr", ops_q[i].addr, exp_ops[i].addr);
      if (exp_ops[i].we) chk("bus_op_wdata", ops_q[i].data, exp_ops[i].data);
    end
  endtask

  task automatic run(input logic t_we, input logic [1:0] t_size, input logic t_uns,
                     input logic [31:0] t_addr, input logic [31:0] t_wdata, input int stall,
                     input bit hold);
    start_txn(t_we, t_size, t_uns, t_addr, t_wdata, stall);
    finish_txn(hold);
  endtask

  // ---------------- per-cycle compare ----------------
  bit          prev_valid = 1'b0, prev_req, prev_gnt, prev_we;
  logic [31:0] prev_addr, prev_wdata;

  initial begin
    bit in_win, is_done;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        in_win  = m_active && (cyc >= m_start);
        is_done = in_win && (cyc == m_done);
        chk("busy", 32'(busy), 32'(in_win));
        chk("done", 32'(done), 32'(is_done));
        if (done) done_seen = cyc;
        if (is_done) begin
          chk("err_at_done", 32'(err), 32'(m_err_p));
          chk("rdata_at_done", rdata, m_rdata_p);
          held_err   = m_err_p;
          held_rdata = m_rdata_p;
          m_active   = 1'b0;
        end else begin
          chk("err_hold", 32'(err), 32'(held_err));
          chk("rdata_hold", rdata, held_rdata);
        end
        if (!in_win) chk("bus_req_idle", 32'(bus_req), 32'h0);
        if (!bus_req) begin
          chk("bus_addr_zero", bus_addr, 32'h0);
          chk("bus_we_wdata_zero", bus_wdata | 32'(bus_we), 32'h0);
        end
        if (prev_valid && prev_req && !prev_gnt && bus_req) begin
          chk("stall_addr", bus_addr, prev_addr);
          chk("stall_we", 32'(bus_we), 32'(prev_we));
          chk("stall_wdata", bus_wdata, prev_wdata);
        end
        prev_valid = 1'b1;
        prev_req = bus_req; prev_gnt = bus_gnt; prev_we = bus_we;
        prev_addr = bus_addr; prev_wdata = bus_wdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0; addr = '0; wdata = '0;
    mem[32'h1000] = 32'h80AA_BBCC;
    mem[32'h2000] = 32'hDEAD_BEEF;
    mem[32'h3000] = 32'h1111_1111;
    mem[32'h5000] = 32'h0F0E_8D0C;
    mem[32'h6000] = 32'h0123_4567;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    32'(busy), 32'h0);
    chk("rst_done",    32'(done), 32'h0);
    chk("rst_err",     32'(err), 32'h0);
    chk("rst_rdata",   rdata, 32'h0);
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // signed byte load at the top lane
    run(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 0, 1'b0);
    chk("t1_rdata", rdata, 32'hFFFF_FF80);
    chk("t1_latency", 32'(done_seen - last_start + 1), 32'd3);
    chk("t1_read_addr", ops_q[0].addr, 32'h1000);

    // half store read-modify-write
    run(1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000_1234, 0, 1'b0);
    chk("t2_mem", mem_rd(32'h2000), 32'h1234_BEEF);
    chk("t2_latency", 32'(done_seen - last_start + 1), 32'd4);
    chk("t2_rdata_after_store", rdata, 32'h0);

    // word store with three stalled cycles
    run(1'b1, 2'b10, 1'b0, 32'h3000, 32'hCAFE_F00D, 3, 1'b0);
    chk("t3_latency", 32'(done_seen - last_start + 1), 32'd5);
    chk("t3_single_write", 32'(ops_q.size()), 32'd1);
    chk("t3_mem", mem_rd(32'h3000), 32'hCAFE_F00D);

    // misaligned word load
    run(1'b0, 2'b10, 1'b0, 32'h4002, 32'h0, 0, 1'b0);
    chk("t4_err", 32'(err), 32'h1);
    chk("t4_rdata", rdata, 32'h0);
    chk("t4_latency", 32'(done_seen - last_start + 1), 32'd1);

    // extension variants, requests held high while busy, back-to-back accepts
    run(1'b0, 2'b01, 1'b0, 32'h5000, 32'h0, 0, 1'b1);
    chk("t5_rdata", rdata, 32'hFFFF_8D0C);
    run(1'b0, 2'b01, 1'b1, 32'h5002, 32'h0, 1, 1'b1);
    run(1'b0, 2'b00, 1'b1, 32'h5001, 32'h0, 0, 1'b1);
    chk("t7_rdata", rdata, 32'h0000_008D);
    run(1'b0, 2'b00, 1'b0, 32'h5001, 32'h0, 0, 1'b0);
    run(1'b0, 2'b10, 1'b0, 32'h6000, 32'h0, 2, 1'b1);
    run(1'b1, 2'b00, 1'b0, 32'h6001, 32'hFFFF_FFAB, 1, 1'b1);
    chk("t10_mem", mem_rd(32'h6000), 32'h0123_AB67);
    run(1'b0, 2'b11, 1'b0, 32'h6000, 32'h0, 0, 1'b1);
    run(1'b1, 2'b01, 1'b0, 32'h6003, 32'h1, 0, 1'b0);
    run(1'b1, 2'b00, 1'b0, 32'h6003, 32'h0000_0099, 0, 1'b0);
    chk("t13_mem", mem_rd(32'h6000), 32'h9923_AB67);

    // reset while a read waits for grant
    start_txn(1'b0, 2'b10, 1'b0, 32'h5004, 32'h0, 10);
    @(posedge clk);
    #1;
    req = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_bus_req", 32'(bus_req), 32'h0);
    chk("mid_rst_busy",    32'(busy), 32'h0);
    chk("mid_rst_done",    32'(done), 32'h0);
    chk("mid_rst_rdata",   rdata, 32'h0);
    chk("mid_rst_bus_addr", bus_addr, 32'h0);
    m_active   = 1'b0;
    held_err   = 1'b0;
    held_rdata = 32'h0;
    stall_left = 0;
    exp_ops.delete();
    ops_q.delete();
    @(posedge clk);
    #1;
    // request presented during reset; the first edge after release accepts it
    start_txn(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 0);
    @(negedge clk);
    rst = 1'b0;
    finish_txn(1'b0);
    chk("t14_rdata", rdata, 32'h80AA_BBCC);
    chk("t14_latency", 32'(done_seen - last_start + 1), 32'd3);

    repeat (2) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
